shift_frame_reg: RTL and testbench

- Parametrised universal shift register that generalises the team's 4-bit serial-in/parallel-out shifter.
- Supports configurable width, right/left serial shift, parallel load, hold, a clock-enable, and a serial output.
- A bit counter emits a one-cycle frame strobe each time WIDTH bits have been shifted in.
- Sits between serial front-ends (keypad/UART-style bit streams) and parallel consumers such as display and clock-setting logic.

---
 rtl/shift_frame_reg.sv | 78 +++++++
 tb/tb_shift_frame_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with clock enable.
// A shift counter raises a one-cycle frame strobe once WIDTH bits have been shifted in.
module shift_frame_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_valid
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic             shift_edge;

  assign shift_edge = en && (mode == MODE_RIGHT || mode == MODE_LEFT);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    fv_d  = 1'b0;
    if (en) begin
      case (mode)
        MODE_RIGHT: q_d = {sin, q_q[WIDTH-1:1]};
        MODE_LEFT:  q_d = {q_q[WIDTH-2:0], sin};
        MODE_LOAD: begin
          q_d   = pdata;
          cnt_d = '0;
        end
        default:    q_d = q_q;
      endcase
    end
    // The counter ignores direction: any mix of left and right shifts makes up a frame.
    if (shift_edge) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        fv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q   <= '0;
      cnt_q <= '0;
      fv_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      fv_q  <= fv_d;
    end
  end

  assign q           = q_q;
  assign bit_cnt     = cnt_q;
  assign frame_valid = fv_q;
  // sout is the bit the selected direction would push out next.
  assign sout        = (mode == MODE_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shift_frame_reg.sv
// Self-checking bench for shift_frame_reg (WIDTH=4): vector table, hand-written
// reset/wrap sequences, and randomized traffic against a shift-count reference model.
module tb_shift_frame_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         en;
  logic [1:0]   mode;
  logic         sin;
  logic [W-1:0] pdata;
  logic [W-1:0] q;
  logic         sout;
  logic [2:0]   bit_cnt;
  logic         frame_valid;

  int total  = 0;
  int passed = 0;

  shift_frame_reg #(.WIDTH(W), .CNT_W(3)) dut (
    .clk         (clk),
    .clear       (clear),
    .en          (en),
    .mode        (mode),
    .sin         (sin),
    .pdata       (pdata),
    .q           (q),
    .sout        (sout),
    .bit_cnt     (bit_cnt),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic       s;
    logic [3:0] p;
    logic [3:0] xq;
    logic [2:0] xc;
    logic       xf;
    logic       xs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic s,
                              input logic [3:0] p, input logic [3:0] xq,
                              input logic [2:0] xc, input logic xf, input logic xs);
    vec_t v;
    v.e = e; v.m = m; v.s = s; v.p = p; v.xq = xq; v.xc = xc; v.xf = xf; v.xs = xs;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step(input logic e, input logic [1:0] m, input logic s, input logic [3:0] p);
    en = e; mode = m; sin = s; pdata = p;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    clear = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_cnt", int'(bit_cnt), 0);
    chk("rst_fv", int'(frame_valid), 0);
    clear = 1'b1;
  endtask

  // Reference model: state is the register value plus the number of shifts since
  // the last load/reset; the frame strobe fires whenever that total hits a multiple of W.
  int m_q, m_shifts, m_fv;

  task automatic model_apply(input logic e, input logic [1:0] m, input logic s, input logic [3:0] p);
    m_fv = 0;
    if (e) begin
      if (m == 2'd1) m_q = (m_q >> 1) | (int'(s) << (W - 1));
      else if (m == 2'd2) m_q = ((m_q << 1) | int'(s)) & ((1 << W) - 1);
      else if (m == 2'd3) begin m_q = int'(p); m_shifts = 0; end
      if (m == 2'd1 || m == 2'd2) begin
        m_shifts++;
        m_fv = (m_shifts % W == 0) ? 1 : 0;
      end
    end
  endtask

  initial begin
    clear = 1'b0; en = 1'b0; mode = 2'b00; sin = 1'b0; pdata = '0;
    #2;
    chk("init_q", int'(q), 0);
    chk("init_cnt", int'(bit_cnt), 0);
    chk("init_fv", int'(frame_valid), 0);
    #1 clear = 1'b1;
    @(posedge clk); #1;

    // en, mode, sin, pdata -> q, bit_cnt, frame_valid, sout
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1000, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0100, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1010, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1101, 3'd0, 1, 1));
    tbl.push_back(mk(1, 2'b00, 0, 4'h0, 4'b1101, 3'd0, 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 4'hA, 4'b1010, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0101, 3'd1, 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 4'h0, 4'b0000, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 4'h0, 4'b0001, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 4'h0, 4'b0011, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0110, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 4'h0, 4'b1101, 3'd0, 1, 1));
    tbl.push_back(mk(1, 2'b11, 0, 4'h0, 4'b0000, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1000, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0100, 3'd2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 4'h0, 4'b0100, 3'd2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 4'h0, 4'b0100, 3'd2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 4'h0, 4'b0100, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1010, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1101, 3'd0, 1, 1));
    tbl.push_back(mk(0, 2'b01, 0, 4'h0, 4'b1101, 3'd0, 0, 1));
    tbl.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0110, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 4'h0, 4'b1101, 3'd2, 0, 1));
    tbl.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0110, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 4'h0, 4'b1100, 3'd0, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].p);
      chk($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].xq));
      chk($sformatf("vec%0d_cnt", i), int'(bit_cnt), int'(tbl[i].xc));
      chk($sformatf("vec%0d_fv", i), int'(frame_valid), int'(tbl[i].xf));
      chk($sformatf("vec%0d_sout", i), int'(sout), int'(tbl[i].xs));
    end

    // Async reset mid-frame, between clock edges.
    pulse_reset();
    step(1, 2'b01, 0, 4'h0);
    step(1, 2'b01, 1, 4'h0);
    chk("mid_q", int'(q), 4'b1000);
    chk("mid_cnt", int'(bit_cnt), 2);
    #2;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, 1, 4'h0);
      chk($sformatf("postrst%0d_fv", i), int'(frame_valid), (i == 3) ? 1 : 0);
    end
    // Reset while the strobe is high.
    #1;
    pulse_reset();

    // Continuous wrap: 8 back-to-back right shifts, sin = 1,0,1,0,...
    for (int i = 1; i <= 8; i++) begin
      step(1, 2'b01, (i % 2 == 1) ? 1'b1 : 1'b0, 4'h0);
      chk($sformatf("wrap%0d_fv", i), int'(frame_valid), (i % 4 == 0) ? 1 : 0);
      chk($sformatf("wrap%0d_cnt", i), int'(bit_cnt), i % 4);
      if (i % 4 == 0) chk($sformatf("wrap%0d_q", i), int'(q), 4'b0101);
    end

    // Randomized traffic against the reference model.
    pulse_reset();
    m_q = 0; m_shifts = 0; m_fv = 0;
    for (int i = 0; i < 400; i++) begin
      logic       e, s;
      logic [1:0] m;
      logic [3:0] p;
      e = ($urandom_range(0, 7) != 0);
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && m == 2'b11) m = 2'b01;
      s = 1'($urandom_range(0, 1));
      p = 4'($urandom_range(0, 15));
      step(e, m, s, p);
      model_apply(e, m, s, p);
      chk($sformatf("rnd%0d_q", i), int'(q), m_q);
      chk($sformatf("rnd%0d_cnt", i), int'(bit_cnt), m_shifts % W);
      chk($sformatf("rnd%0d_fv", i), int'(frame_valid), m_fv);
      chk($sformatf("rnd%0d_sout", i), int'(sout),
          (m == 2'b10) ? ((m_q >> (W - 1)) & 1) : (m_q & 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
